cac_fns_decoder: RTL



---
 rtl/cac_fns_decoder.sv | 111 +++++++++++
 1 files changed

// File: rtl/cac_fns_decoder.sv
// Bit-serial decoder for Fibonacci-numeral-system CAC codewords: sums code[i]*F(i)
// one bit per cycle and flags words containing adjacent ones (non-Zeckendorf).
//
// state  | meaning
// IDLE   | in_ready high, waiting for a codeword
// RUN    | accumulating one codeword bit per cycle, LSB first
// DONE   | out_valid high, result held until out_ready
module cac_fns_decoder #(
  parameter int CW = 8,
  parameter int BW = 6
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic [CW-1:0] code_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [BW-1:0] data_out,
  output logic          err_out,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int CNTW = (CW > 2) ? $clog2(CW) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   code_q;
  logic [BW-1:0]   acc;
  logic [BW-1:0]   w;
  logic [BW-1:0]   wp;
  logic [CNTW-1:0] cnt;
  logic            prev;
  logic            err;

  logic [BW-1:0]   acc_nx;
  logic            err_nx;

  // code_q shifts right, so bit 0 is always the bit of weight w
  always_comb begin
    acc_nx = acc;
    if (code_q[0]) acc_nx = acc + w;
    err_nx = err | (code_q[0] & prev);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      data_out  <= '0;
      err_out   <= 1'b0;
      code_q    <= '0;
      acc       <= '0;
      w         <= '0;
      wp        <= '0;
      cnt       <= '0;
      prev      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            code_q   <= code_in;
            acc      <= '0;
            w        <= BW'(1);
            wp       <= BW'(1);
            cnt      <= '0;
            prev     <= 1'b0;
            err      <= 1'b0;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          acc    <= acc_nx;
          err    <= err_nx;
          prev   <= code_q[0];
          w      <= w + wp;
          wp     <= w;
          cnt    <= cnt + CNTW'(1);
          code_q <= code_q >> 1;
          if (cnt == CNT_LAST) begin
            data_out  <= acc_nx;
            err_out   <= err_nx;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
